// File: rtl/cordic_seq_ctrl_if.sv
// Wishbone slave bundle between the management SoC and the CORDIC sequencer.
interface cordic_seq_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/cordic_seq_ctrl.sv
// Wishbone-fed job sequencer for a shared CORDIC core: command FIFO in, one job at a time,
// result FIFO out, level interrupt.
module cordic_seq_ctrl #(
  parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
  parameter int unsigned ANGLE_W    = 16,
  parameter int unsigned EXP_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  cordic_seq_ctrl_if.slave   wb,
  output logic               core_start_o,
  output logic [ANGLE_W-1:0] core_angle_o,
  input  logic [EXP_W-1:0]   core_exp_i,
  input  logic               core_done_i,
  output logic               irq_o
);

  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW    = $clog2(TIMEOUT);
  localparam int unsigned ResW    = ANGLE_W + EXP_W;
  localparam logic [3:0]  FullCnt = 4'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StLaunch, StBusy, StStore} state_e;

  state_e state_q, state_d;

  logic               ack_q;
  logic [31:0]        dat_q;
  logic               enable_q, irq_en_q, irq_q;
  logic               ovf_q, udf_q, tmo_q;
  logic [ANGLE_W-1:0] angle_q;
  logic [EXP_W-1:0]   exp_q;
  logic [CntW-1:0]    tmo_cnt_q;

  logic [ANGLE_W-1:0] cmd_mem [FIFO_DEPTH];
  logic [ResW-1:0]    res_mem [FIFO_DEPTH];
  logic [PtrW-1:0]    cmd_wp_q, cmd_rp_q, res_wp_q, res_rp_q;
  logic [3:0]         cmd_cnt_q, res_cnt_q;

  logic        req, wr, rd;
  logic [1:0]  off;
  logic        cmd_full, cmd_empty, res_full, res_empty;
  logic        cmd_wr, cmd_push, cmd_pop, ovf_set;
  logic        res_rd, res_push, res_pop, udf_set;
  logic        ctrl_wr, err_clr, tmo_set;
  logic [ResW-1:0] res_head;
  logic [31:0] res_word, status, rdata;
  logic        unused_bits;

  assign req = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q &
               (wb.wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign off = wb.wbs_adr_i[3:2];
  assign wr  = req & wb.wbs_we_i;
  assign rd  = req & ~wb.wbs_we_i;

  assign cmd_full  = (cmd_cnt_q == FullCnt);
  assign cmd_empty = (cmd_cnt_q == 4'd0);
  assign res_full  = (res_cnt_q == FullCnt);
  assign res_empty = (res_cnt_q == 4'd0);

  // A simultaneous pop frees a slot, so a push into a full FIFO is still taken then.
  assign cmd_pop  = (state_q == StLaunch);
  assign cmd_wr   = wr & (off == 2'd0);
  assign cmd_push = cmd_wr & (~cmd_full | cmd_pop);
  assign ovf_set  = cmd_wr & ~cmd_push;

  assign res_rd   = rd & (off == 2'd1);
  assign res_pop  = res_rd & ~res_empty;
  assign udf_set  = res_rd & res_empty;
  assign res_push = (state_q == StStore) & (~res_full | res_pop);

  assign ctrl_wr = wr & (off == 2'd3);
  assign err_clr = ctrl_wr & wb.wbs_dat_i[2];

  assign res_head = res_mem[res_rp_q];
  assign res_word = {16'(res_head[ResW-1:EXP_W]), 16'(res_head[EXP_W-1:0])};
  assign status   = {16'd0, res_cnt_q, cmd_cnt_q, tmo_q, udf_q, ovf_q,
                     res_empty, res_full, cmd_empty, cmd_full, (state_q != StIdle)};

  always_comb begin
    rdata = '0;
    case (off)
      2'd0, 2'd2: rdata = status;
      2'd1:       rdata = res_empty ? 32'd0 : res_word;
      default:    rdata = {30'd0, irq_en_q, enable_q};
    endcase
  end

  always_comb begin
    state_d      = state_q;
    tmo_set      = 1'b0;
    core_start_o = 1'b0;
    core_angle_o = angle_q;
    unique case (state_q)
      StIdle:   if (enable_q && !cmd_empty) state_d = StLaunch;
      StLaunch: begin
        core_start_o = 1'b1;
        core_angle_o = cmd_mem[cmd_rp_q];
        state_d      = StBusy;
      end
      StBusy: begin
        if (core_done_i) begin
          state_d = StStore;
        end else if (tmo_cnt_q == CntW'(TIMEOUT - 1)) begin
          tmo_set = 1'b1;
          state_d = StIdle;
        end
      end
      StStore:  if (res_push) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FIFO storage carries no reset; validity is tracked by the counters.
  always_ff @(posedge wb_clk_i) begin
    if (cmd_push) cmd_mem[cmd_wp_q] <= wb.wbs_dat_i[ANGLE_W-1:0];
    if (res_push) res_mem[res_wp_q] <= {angle_q, exp_q};
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      enable_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      tmo_q     <= 1'b0;
      angle_q   <= '0;
      exp_q     <= '0;
      tmo_cnt_q <= '0;
      cmd_wp_q  <= '0;
      cmd_rp_q  <= '0;
      res_wp_q  <= '0;
      res_rp_q  <= '0;
      cmd_cnt_q <= '0;
      res_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= req;
      dat_q   <= rd ? rdata : 32'd0;

      if (ctrl_wr) begin
        enable_q <= wb.wbs_dat_i[0];
        irq_en_q <= wb.wbs_dat_i[1];
      end
      ovf_q <= (ovf_q & ~err_clr) | ovf_set;
      udf_q <= (udf_q & ~err_clr) | udf_set;
      tmo_q <= (tmo_q & ~err_clr) | tmo_set;
      irq_q <= irq_en_q & (~res_empty | ovf_q | udf_q | tmo_q);

      if (state_q == StLaunch) angle_q <= cmd_mem[cmd_rp_q];
      if (state_q == StBusy && core_done_i) exp_q <= core_exp_i;
      tmo_cnt_q <= (state_q == StBusy) ? tmo_cnt_q + CntW'(1) : '0;

      if (cmd_push) cmd_wp_q <= cmd_wp_q + PtrW'(1);
      if (cmd_pop)  cmd_rp_q <= cmd_rp_q + PtrW'(1);
      if (cmd_push != cmd_pop) cmd_cnt_q <= cmd_push ? cmd_cnt_q + 4'd1 : cmd_cnt_q - 4'd1;

      if (res_push) res_wp_q <= res_wp_q + PtrW'(1);
      if (res_pop)  res_rp_q <= res_rp_q + PtrW'(1);
      if (res_push != res_pop) res_cnt_q <= res_push ? res_cnt_q + 4'd1 : res_cnt_q - 4'd1;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign irq_o        = irq_q;

  assign unused_bits = ^{wb.wbs_sel_i, wb.wbs_adr_i[1:0], wb.wbs_dat_i};

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Randomized bench for cordic_seq_ctrl: bus-level reference of both FIFOs, error flags and a
// behavioural core that answers each launch after a chosen delay.
module tb_cordic_seq_ctrl;
  localparam logic [31:0] Base  = 32'h3000_0000;
  localparam int          Depth = 4;
  localparam logic [31:0] ACmd  = Base + 32'h0;
  localparam logic [31:0] ARes  = Base + 32'h4;
  localparam logic [31:0] AStat = Base + 32'h8;
  localparam logic [31:0] ACtrl = Base + 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_start;
  logic [15:0] core_angle;
  logic [15:0] core_exp;
  logic        core_done;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  logic [15:0] cmd_model[$];
  logic [31:0] res_model[$];
  bit          ovf_m, udf_m, tmo_m;
  int          rst_epoch = 0;
  int          starts = 0;

  // Core behaviour knobs
  int          core_delay = 5;
  bit          core_hang  = 1'b0;
  bit          fixed_en   = 1'b0;
  logic [15:0] fixed_exp  = 16'h0;

  cordic_seq_ctrl_if wb ();

  cordic_seq_ctrl #(
    .BASE_ADR   (Base),
    .ANGLE_W    (16),
    .EXP_W      (16),
    .FIFO_DEPTH (Depth),
    .TIMEOUT    (64)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wb           (wb),
    .core_start_o (core_start),
    .core_angle_o (core_angle),
    .core_exp_i   (core_exp),
    .core_done_i  (core_done),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] status_of(bit busy, int cmd_n, int res_n, bit ovf, bit udf,
                                            bit tmo);
    return {16'd0, 4'(res_n), 4'(cmd_n), tmo, udf, ovf, res_n == 0, res_n == Depth,
            cmd_n == 0, cmd_n == Depth, busy};
  endfunction

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                         input logic exp_ack, output logic [31:0] rdata);
    logic got;
    got   = 1'b0;
    rdata = '0;
    @(negedge clk);
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_sel_i = 4'hF;
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = wdata;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk);
      #1;
      if (wb.wbs_ack_o) begin
        got   = 1'b1;
        rdata = wb.wbs_dat_o;
      end
    end
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    check_eq("ack", 32'(got), 32'(exp_ack));
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] data);
    logic [31:0] d;
    wb_xfer(1'b1, adr, data, 1'b1, d);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] data);
    wb_xfer(1'b0, adr, 32'd0, 1'b1, data);
  endtask

  task automatic cmd_write(input logic [31:0] data);
    if (cmd_model.size() < Depth) cmd_model.push_back(data[15:0]);
    else ovf_m = 1'b1;
    wb_write(ACmd, data);
  endtask

  task automatic read_result(input string tag);
    logic [31:0] d, e;
    wb_read(ARes, d);
    if (res_model.size() == 0) begin
      e     = 32'd0;
      udf_m = 1'b1;
    end else begin
      e = res_model.pop_front();
    end
    check_eq(tag, d, e);
  endtask

  task automatic check_status(input string tag, input bit busy);
    logic [31:0] d;
    int rn;
    rn = (res_model.size() > Depth) ? Depth : res_model.size();
    wb_read(AStat, d);
    check_eq(tag, d, status_of(busy, cmd_model.size(), rn, ovf_m, udf_m, tmo_m));
  endtask

  task automatic wait_idle();
    logic [31:0] d;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      wb_read(AStat, d);
      if (d[0] == 1'b0 && d[11:8] == 4'd0) ok = 1'b1;
    end
    if (!ok) check_eq("idle_wait", 32'd0, 32'd1);
  endtask

  task automatic clear_errors();
    wb_write(ACtrl, 32'h7);
    ovf_m = 1'b0;
    udf_m = 1'b0;
    tmo_m = 1'b0;
  endtask

  // Behavioural core: checks each launch against the command stream, holds done off for
  // core_delay cycles, then returns an Exp and records the job it expects back.
  initial begin : core_model
    logic [15:0] m_ang, m_exp;
    int          m_ep, m_dly;
    core_done = 1'b0;
    core_exp  = 16'h0;
    forever begin
      @(negedge clk);
      if (!rst && core_start) begin
        starts++;
        m_ang = core_angle;
        if (cmd_model.size() == 0) check_eq("launch_unexpected", 32'd1, 32'd0);
        else check_eq("launch_angle", 32'(m_ang), 32'(cmd_model.pop_front()));
        m_ep = rst_epoch;
        if (!core_hang) begin
          m_dly = core_delay;
          m_exp = fixed_en ? fixed_exp : 16'($urandom);
          for (int i = 0; i < m_dly; i++) begin
            @(negedge clk);
            if (m_ep == rst_epoch) check_eq("angle_hold", 32'(core_angle), 32'(m_ang));
          end
          core_done = 1'b1;
          core_exp  = m_exp;
          if (m_ep == rst_epoch) res_model.push_back({m_ang, m_exp});
          @(negedge clk);
          core_done = 1'b0;
          core_exp  = 16'($urandom);
        end
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] d;
    int s0, n;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'h0;
    wb.wbs_adr_i = 32'h0;
    wb.wbs_dat_i = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_start", 32'(core_start), 32'd0);
    rst = 1'b0;
    wb_read(AStat, d);
    check_eq("rst_status", d, 32'h0000_0014);
    wb_read(ACtrl, d);
    check_eq("rst_ctrl", d, 32'd0);
    wb_xfer(1'b0, 32'h4000_0008, 32'd0, 1'b0, d);
    check_eq("miss_data", wb.wbs_dat_o, 32'd0);
    check_eq("rst_no_start", 32'(starts), 32'd0);

    // Single job with exact launch and result latency
    wb_write(ACtrl, 32'h3);
    fixed_en   = 1'b1;
    fixed_exp  = 16'hBEEF;
    core_delay = 5;
    cmd_write(32'hABCD_1234);
    @(negedge clk);
    check_eq("lat_start_c1", 32'(core_start), 32'd0);
    @(negedge clk);
    check_eq("lat_start_c2", 32'(core_start), 32'd1);
    check_eq("lat_angle_c2", 32'(core_angle), 32'h1234);
    repeat (7) @(negedge clk);
    check_eq("lat_irq_k2", 32'(irq), 32'd0);
    @(negedge clk);
    check_eq("lat_irq_k3", 32'(irq), 32'd1);
    read_result("lat_result");
    check_status("lat_status", 1'b0);
    repeat (2) @(negedge clk);
    check_eq("lat_irq_clear", 32'(irq), 32'd0);
    fixed_en = 1'b0;

    // Overflow with launches disabled, then drain in order
    wb_write(ACtrl, 32'h2);
    s0 = starts;
    for (int i = 0; i < 5; i++) cmd_write($urandom);
    check_status("ovf_status", 1'b0);
    repeat (10) @(negedge clk);
    check_eq("ovf_no_launch", 32'(starts), 32'(s0));
    core_delay = int'($urandom_range(1, 6));
    wb_write(ACtrl, 32'h3);
    wait_idle();
    check_status("ovf_drained", 1'b0);
    for (int i = 0; i < 4; i++) read_result("ovf_result");
    clear_errors();
    wb_read(ACtrl, d);
    check_eq("ctrl_readback", d, 32'h3);
    check_status("ovf_cleared", 1'b0);

    // Timeout: core never answers
    core_hang = 1'b1;
    cmd_write($urandom);
    @(negedge clk);
    @(negedge clk);
    check_eq("tmo_launch", 32'(core_start), 32'd1);
    repeat (65) @(negedge clk);
    check_eq("tmo_irq_early", 32'(irq), 32'd0);
    @(negedge clk);
    check_eq("tmo_irq", 32'(irq), 32'd1);
    tmo_m     = 1'b1;
    core_hang = 1'b0;
    check_status("tmo_status", 1'b0);
    core_delay = 3;
    cmd_write($urandom);
    wait_idle();
    read_result("tmo_next_result");
    clear_errors();

    // Result FIFO full: fifth job stalls in STORE until one read
    core_delay = 2;
    for (int i = 0; i < 4; i++) cmd_write($urandom);
    wait_idle();
    check_status("full_status", 1'b0);
    cmd_write($urandom);
    repeat (20) @(negedge clk);
    check_status("stall_status", 1'b1);
    read_result("stall_pop");
    repeat (3) @(negedge clk);
    check_status("stall_released", 1'b0);
    for (int i = 0; i < 4; i++) read_result("stall_result");
    check_status("stall_empty", 1'b0);

    // Randomized batches
    for (int it = 0; it < 25; it++) begin
      n          = int'($urandom_range(1, 3));
      core_delay = int'($urandom_range(1, 8));
      for (int j = 0; j < n; j++) cmd_write($urandom);
      wait_idle();
      check_status("rnd_status", 1'b0);
      while (res_model.size() > 0) read_result("rnd_result");
    end
    read_result("udf_result");
    check_status("udf_status", 1'b0);
    clear_errors();

    // Asynchronous reset during BUSY
    core_delay = 30;
    cmd_write(32'h0000_5A5A);
    cmd_write(32'h0000_0101);
    wb_write(ACtrl, 32'h0);
    repeat (8) @(negedge clk);
    rst_epoch++;
    rst = 1'b1;
    #1;
    check_eq("arst_start", 32'(core_start), 32'd0);
    check_eq("arst_angle", 32'(core_angle), 32'd0);
    check_eq("arst_ack", 32'(wb.wbs_ack_o), 32'd0);
    cmd_model.delete();
    res_model.delete();
    ovf_m = 1'b0;
    udf_m = 1'b0;
    tmo_m = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    s0  = starts;
    check_status("arst_status", 1'b0);
    read_result("arst_udf_read");
    check_status("arst_udf_status", 1'b0);
    repeat (40) @(negedge clk);
    check_eq("arst_no_relaunch", 32'(starts), 32'(s0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cordic_seq_ctrl.md
Name: cordic_seq_ctrl

Overview:
- Wishbone-slave sequencer that shares one CORDIC core (start/angle/Exp/done interface) with firmware on the management SoC.
- Angles written over Wishbone queue in a command FIFO. The block launches the core one job at a time, captures each result into a result FIFO, and raises an interrupt.
- Sits inside user_project_wrapper, between the WB MI A port and the cordic core.

Parameters:
- BASE_ADR, 32'h3000_0000, slave base address; 16-byte window decoded on adr[31:4].
- ANGLE_W, 16, angle width to core.
- EXP_W, 16, result width from core.
- FIFO_DEPTH, 4, depth of both FIFOs; legal values 2, 4, 8.
- TIMEOUT, 64, max BUSY cycles before abort (>=2).

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  asynchronous active-high reset
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects (ignored)
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  address
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- core_start_o  out  1  one-cycle launch pulse to core
- core_angle_o  out  ANGLE_W  angle to core; held stable from launch until the job ends
- core_exp_i  in  EXP_W  core result
- core_done_i  in  1  core completion pulse
- irq_o  out  1  level interrupt

Behaviour:
- Reset: all outputs 0, both FIFOs empty, FSM in IDLE, CTRL=0, sticky errors 0, timeout counter 0. Reset is asynchronous and may arrive mid-job; it aborts the job without issuing a further core_start_o.
- Request acceptance: a request is accepted when stb & cyc & !ack_o & adr[31:4]==BASE_ADR[31:4]. wbs_ack_o is a registered 1-cycle pulse in the next cycle; no ack is given on an address miss. wbs_dat_o is valid with ack and is 0 otherwise.
- Register map (offset = adr[3:2]):
  - 0x0 CMD. Write pushes dat[ANGLE_W-1:0]. Read returns STATUS.
  - 0x4 RESULT. Read pops {angle[15:0], exp[15:0]}. Writes are ignored.
  - 0x8 STATUS (read-only):
    - [0] busy (FSM != IDLE)
    - [1] cmd_full, [2] cmd_empty
    - [3] res_full, [4] res_empty
    - [5] ovf, [6] udf, [7] tmo
    - [11:8] cmd_count, [15:12] res_count
    - others 0
  - 0xC CTRL:
    - [0] enable (R/W)
    - [1] irq_en (R/W)
    - [2] write 1 clears ovf/udf/tmo, reads 0
- FIFO boundary conditions:
  - CMD write when cmd_full: data dropped, ovf set, still acked.
  - RESULT read when res_empty: returns 0, udf set, acked.
  - Push and pop on the same FIFO in the same cycle is legal; count is unchanged. This holds for CMD (WB push, FSM pop) and RESULT (FSM push, WB pop), and also when full.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: moves to LAUNCH when enable & !cmd_empty.
  - LAUNCH: core_start_o=1 and core_angle_o=cmd head for this single cycle. Pops CMD and loads the angle register. Moves to BUSY.
  - BUSY: counts cycles.
    - core_done_i: capture core_exp_i, move to STORE.
    - Otherwise, when count reaches TIMEOUT-1: set tmo, discard the job, return to IDLE.
    - done and timeout in the same cycle: done wins.
  - STORE: if !res_full, push {angle, exp} and return to IDLE. Otherwise stay in STORE; the core is not relaunched while stalled.
- core_done_i outside BUSY is ignored.
- Clearing enable mid-job lets the current job finish; no new launch occurs.
- Latency: a CMD write presented in cycle 0 (idle, enabled, empty FIFO) gives ack in cycle 1 and core_start_o in cycle 2. core_done_i in cycle k gives a result readable (res_empty=0) in cycle k+2.
- Back-to-back jobs: from STORE push to the next core_start_o is 2 cycles (IDLE, then LAUNCH).
- irq_o = irq_en & (!res_empty | ovf | udf | tmo), registered.
- Width rules:
  - Angle truncated to ANGLE_W on write and zero-extended to 16 in RESULT.
  - Exp zero-extended to 16.
  - Counts are 4 bits, holding values 0..FIFO_DEPTH.

Test Plan:
- Reset then read STATUS -> 0x0000_0014 (cmd_empty, res_empty). irq_o=0; core_start_o never pulses.
- CTRL=0x3, write CMD 0x1234, core model returns done with Exp 0xBEEF 5 cycles after start -> core_start_o in cycle 2 with angle 0x1234. irq_o rises. RESULT read = 0x1234_BEEF; then res_empty=1 and irq_o=0.
- Enable=0, write 5 angles (depth 4) -> first 4 queued, ovf=1, cmd_count=4, no launch. Set enable -> 4 sequential jobs complete; results read back in order. Write CTRL bit2 -> ovf clears.
- Core never asserts done -> after 64 BUSY cycles tmo=1, busy=0, result FIFO unchanged. The next queued angle then launches normally.
- Fill RESULT (4 jobs unread), queue a 5th -> FSM holds in STORE, busy=1. One RESULT read -> 5th result pushed in the same or next cycle; res_count returns to 4.
- Assert wb_rst_i during BUSY -> core_start_o=0, all counts 0 immediately (asynchronous). After release, an empty RESULT read returns 0 and sets udf=1.
